dma_desc_mem_arb: RTL

DMA_DESC_MEM_ARB -- requirements
Module: dma_desc_mem_arb

---
 rtl/dma_pkg.sv | 33 +++
 rtl/dma_desc_mem_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor memory arbiter.
// Holds the arbiter FSM state encoding, the bus width constants, the
// read-burst timeout threshold and the registered command payload layout.
package dma_pkg;

    localparam int unsigned ADDR_W                  = 32;
    localparam int unsigned DATA_W                  = 32;
    localparam int unsigned BE_W                    = DATA_W / 8;
    localparam int unsigned BCOUNT_W                = 4;
    localparam int unsigned TMO_W                   = 8;
    localparam int unsigned DESC_ARB_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CMD  = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_CMD  = 2'd3
    } arb_state_e;

    // Command captured from the granted requester and held on the master bus
    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [BCOUNT_W-1:0] bcount;
        logic [DATA_W-1:0]   data;
        logic [BE_W-1:0]     be;
    } mem_cmd_t;

    // A burst count of zero still moves one beat
    function automatic logic [BCOUNT_W-1:0] adj_bcount(input logic [BCOUNT_W-1:0] b);
        return (b == '0) ? BCOUNT_W'(1) : b;
    endfunction

endpackage

// File: rtl/dma_desc_mem_arb.sv
// DMA descriptor memory arbiter.
// Merges descriptor-fetch burst reads and status-update single writes onto one
// Avalon-MM master, one transaction outstanding at a time, round-robin between
// the two requesters (write wins first after reset).
//
// Ports:
//   clk, reset             - clock, synchronous active-low reset
//   fetch_*                - burst read requester (read, bcount, addr in;
//                            waitrequest, rddata, readdatavalid out)
//   upd_*                  - single write requester (wr, data, be, addr in;
//                            wait_req out)
//   m_*                    - Avalon-MM master towards memory
//   err_timeout_o          - one-cycle pulse when a read burst times out
//
// Optional feature: define DMA_DESC_ARB_TIMEOUT_EN to abandon a read burst after
// DESC_ARB_TIMEOUT_CYCLES consecutive cycles without a beat.
module dma_desc_mem_arb
    import dma_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_read_i,
    input  logic [BCOUNT_W-1:0] fetch_bcount_i,
    input  logic [ADDR_W-1:0]   fetch_addr_i,
    output logic                fetch_waitrequest_o,
    output logic [DATA_W-1:0]   fetch_rddata_o,
    output logic                fetch_readdatavalid_o,
    input  logic                upd_wr_i,
    input  logic [DATA_W-1:0]   upd_data_i,
    input  logic [BE_W-1:0]     upd_be_i,
    input  logic [ADDR_W-1:0]   upd_addr_i,
    output logic                upd_wait_req_o,
    output logic                m_read_o,
    output logic                m_write_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [BCOUNT_W-1:0] m_bcount_o,
    output logic [DATA_W-1:0]   m_wrdata_o,
    output logic [BE_W-1:0]     m_be_o,
    input  logic                m_waitrequest_i,
    input  logic [DATA_W-1:0]   m_rddata_i,
    input  logic                m_readdatavalid_i,
    output logic                err_timeout_o
);

    arb_state_e          state, state_d;
    mem_cmd_t            cmd, cmd_d;
    logic [BCOUNT_W-1:0] beat_cnt, beat_cnt_d;
    logic                last_wr, last_wr_d;   // 1: previous grant went to the writer
    logic                grant_wr;
    logic [BCOUNT_W-1:0] fetch_bcount_adj;

`ifdef DMA_DESC_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
    logic                err_d;
`endif

    assign fetch_bcount_adj = adj_bcount(fetch_bcount_i);

    // Next-state, grant and command capture
    always_comb begin
        state_d    = state;
        cmd_d      = cmd;
        beat_cnt_d = beat_cnt;
        last_wr_d  = last_wr;
        grant_wr   = 1'b0;
`ifdef DMA_DESC_ARB_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt;
        err_d      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (fetch_read_i || upd_wr_i) begin
                    // Under contention the requester not served last wins
                    grant_wr = upd_wr_i && (!fetch_read_i || !last_wr);
                    if (grant_wr) begin
                        cmd_d     = '{addr: upd_addr_i, bcount: BCOUNT_W'(1),
                                      data: upd_data_i, be: upd_be_i};
                        last_wr_d = 1'b1;
                        state_d   = ST_WR_CMD;
                    end else begin
                        cmd_d      = '{addr: fetch_addr_i, bcount: fetch_bcount_adj,
                                       data: '0, be: '1};
                        beat_cnt_d = fetch_bcount_adj;
                        last_wr_d  = 1'b0;
                        state_d    = ST_RD_CMD;
                    end
`ifdef DMA_DESC_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_RD_CMD: begin
                if (!m_waitrequest_i) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_readdatavalid_i) begin
                    beat_cnt_d = beat_cnt - BCOUNT_W'(1);
                    if (beat_cnt == BCOUNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
`ifdef DMA_DESC_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (tmo_cnt == TMO_W'(DESC_ARB_TIMEOUT_CYCLES - 1)) begin
                    // This cycle is the last tolerated idle one: give up on the burst
                    tmo_cnt_d = '0;
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + TMO_W'(1);
`endif
                end
            end
            ST_WR_CMD: begin
                if (!m_waitrequest_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Command, beat counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd      <= '0;
            beat_cnt <= '0;
            last_wr  <= 1'b0;
        end else begin
            cmd      <= cmd_d;
            beat_cnt <= beat_cnt_d;
            last_wr  <= last_wr_d;
        end
    end

    // Read data returns to the fetch side one cycle later, in or out of a burst
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_rddata_o        <= '0;
            fetch_readdatavalid_o <= 1'b0;
        end else begin
            fetch_rddata_o        <= m_rddata_i;
            fetch_readdatavalid_o <= m_readdatavalid_i;
        end
    end

`ifdef DMA_DESC_ARB_TIMEOUT_EN
    // Idle-cycle counter and timeout pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt       <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            tmo_cnt       <= tmo_cnt_d;
            err_timeout_o <= err_d;
        end
    end
`else
    assign err_timeout_o = 1'b0;
`endif

    // Master bus driven straight from the state and the held command
    assign m_read_o   = (state == ST_RD_CMD);
    assign m_write_o  = (state == ST_WR_CMD);
    assign m_addr_o   = cmd.addr;
    assign m_bcount_o = cmd.bcount;
    assign m_wrdata_o = cmd.data;
    assign m_be_o     = cmd.be;

    // Requester is released only in the cycle its command is accepted
    assign fetch_waitrequest_o = !((state == ST_RD_CMD) && !m_waitrequest_i);
    assign upd_wait_req_o      = !((state == ST_WR_CMD) && !m_waitrequest_i);

endmodule
